// File: rtl/score_fetch_sequencer_pkg.sv
// Shared types for the score fetch sequencer: FSM states, neighbour tag codes
// and the score-RAM address width helper.
package nw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] TAG_DIAG = 2'd0;
    localparam logic [1:0] TAG_UP   = 2'd1;
    localparam logic [1:0] TAG_LEFT = 2'd2;

    // Address bits needed to reach every cell of an (n+1)x(n+1) matrix.
    function automatic int addr_width(input int n);
        return $clog2((n + 1) * (n + 1));
    endfunction

endpackage

// File: rtl/score_fetch_sequencer_rd_tag_pipe.sv
// Valid+tag delay line matching the score-RAM read latency, so each returning
// word can be steered into the right neighbour register.
module rd_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] in_tag,
    output logic       out_valid,
    output logic [1:0] out_tag
);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic       valid_q;
            logic [1:0] tag_q;
            logic       valid_d;
            logic [1:0] tag_d;

            if (gi == 0) begin : g_head
                assign valid_d = in_valid;
                assign tag_d   = in_tag;
            end else begin : g_body
                assign valid_d = g_stage[gi-1].valid_q;
                assign tag_d   = g_stage[gi-1].tag_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    tag_q   <= 2'd0;
                end else begin
                    valid_q <= valid_d;
                    tag_q   <= tag_d;
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[DEPTH-1].valid_q;
    assign out_tag   = g_stage[DEPTH-1].tag_q;

endmodule

// File: rtl/score_fetch_sequencer.sv
// Fetches the diagonal, up and left neighbour scores of one matrix cell from a
// fixed-latency score RAM and presents them as a held, handshaked bundle.
module score_fetch_sequencer
    import nw_pkg::*;
#(
    parameter int N       = 128,
    parameter int SCORE_W = 16,
    parameter int RD_LAT  = 1,
    localparam int IDX_W  = $clog2(N + 1),
    localparam int ADDR_W = addr_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IDX_W-1:0]   i_idx,
    input  logic [IDX_W-1:0]   j_idx,
    output logic               busy,
    output logic               ram_en,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [SCORE_W-1:0] ram_rdata,
    output logic [SCORE_W-1:0] diag_score,
    output logic [SCORE_W-1:0] up_score,
    output logic [SCORE_W-1:0] left_score,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               err
);

    localparam logic [IDX_W-1:0]  N_IDX  = IDX_W'(N);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(N + 1);
    localparam logic [ADDR_W-1:0] UP_TO_LEFT = ADDR_W'(N);

    state_t              state_q;
    logic                busy_q;
    logic                ram_en_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [1:0]          tag_q;
    logic [SCORE_W-1:0]  diag_q;
    logic [SCORE_W-1:0]  up_q;
    logic [SCORE_W-1:0]  left_q;
    logic                out_valid_q;
    logic                err_q;

    logic                ret_valid;
    logic [1:0]          ret_tag;
    logic                idx_bad;
    logic [ADDR_W-1:0]   diag_addr;

    assign idx_bad   = (i_idx >= N_IDX) || (j_idx >= N_IDX);
    assign diag_addr = ADDR_W'(i_idx) * STRIDE + ADDR_W'(j_idx);

    // The tag travels alongside the registered enable, i.e. in the issue cycle.
    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ram_en_q),
        .in_tag    (tag_q),
        .out_valid (ret_valid),
        .out_tag   (ret_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            tag_q       <= TAG_DIAG;
            diag_q      <= '0;
            up_q        <= '0;
            left_q      <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (idx_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q    <= ST_ISSUE;
                            busy_q     <= 1'b1;
                            ram_en_q   <= 1'b1;
                            ram_addr_q <= diag_addr;
                            tag_q      <= TAG_DIAG;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (tag_q == TAG_DIAG) begin
                        ram_addr_q <= ram_addr_q + ADDR_W'(1);
                        tag_q      <= TAG_UP;
                    end else if (tag_q == TAG_UP) begin
                        // up is (j+1,i); left is (j,i+1): one stride minus one further
                        ram_addr_q <= ram_addr_q + UP_TO_LEFT;
                        tag_q      <= TAG_LEFT;
                    end else begin
                        ram_en_q   <= 1'b0;
                        ram_addr_q <= '0;
                        tag_q      <= TAG_DIAG;
                        state_q    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ret_valid && ret_tag == TAG_LEFT) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (ret_valid) begin
                case (ret_tag)
                    TAG_DIAG: diag_q <= ram_rdata;
                    TAG_UP:   up_q   <= ram_rdata;
                    TAG_LEFT: left_q <= ram_rdata;
                    default:  ;
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign ram_en     = ram_en_q;
    assign ram_addr   = ram_addr_q;
    assign diag_score = diag_q;
    assign up_score   = up_q;
    assign left_score = left_q;
    assign out_valid  = out_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_score_fetch_sequencer.sv
// Directed bench: N=4 (stride 5), RAM model returns addr*3; one instance at
// RD_LAT=1 and one at RD_LAT=3.
module tb_score_fetch_sequencer;

    localparam int N      = 4;
    localparam int SW     = 16;
    localparam int IDX_W  = $clog2(N + 1);
    localparam int ADDR_W = $clog2((N + 1) * (N + 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // instance A, RD_LAT=1
    logic              start = 1'b0;
    logic [IDX_W-1:0]  i_idx = '0, j_idx = '0;
    logic              busy, ram_en, out_valid, err;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic [SW-1:0]     ram_rdata = '0;
    logic [SW-1:0]     diag, up, left;

    // instance B, RD_LAT=3
    logic              start3 = 1'b0;
    logic [IDX_W-1:0]  i3 = '0, j3 = '0;
    logic              busy3, ram_en3, out_valid3, err3;
    logic              out_ready3 = 1'b0;
    logic [ADDR_W-1:0] ram_addr3;
    logic [SW-1:0]     ram_rdata3 = '0;
    logic [SW-1:0]     diag3, up3, left3;
    logic [ADDR_W-1:0] a3_d1 = '0, a3_d2 = '0;

    score_fetch_sequencer #(.N(N), .SCORE_W(SW), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .i_idx(i_idx), .j_idx(j_idx),
        .busy(busy), .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .diag_score(diag), .up_score(up), .left_score(left),
        .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    score_fetch_sequencer #(.N(N), .SCORE_W(SW), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .i_idx(i3), .j_idx(j3),
        .busy(busy3), .ram_en(ram_en3), .ram_addr(ram_addr3), .ram_rdata(ram_rdata3),
        .diag_score(diag3), .up_score(up3), .left_score(left3),
        .out_valid(out_valid3), .out_ready(out_ready3), .err(err3)
    );

    // RAM models: word at address a holds a*3
    always @(posedge clk) begin
        ram_rdata  <= SW'(ram_addr) * SW'(3);
        a3_d1      <= ram_addr3;
        a3_d2      <= a3_d1;
        ram_rdata3 <= SW'(a3_d2) * SW'(3);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, ram_en, out_valid, err} !== 4'b0000 || ram_addr !== '0 ||
            diag !== '0 || up !== '0 || left !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%0b en=%0b ov=%0b err=%0b addr=%0d expected all zero",
                     busy, ram_en, out_valid, err, ram_addr);
        end
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_fetch();
        i_idx = 3'd1; j_idx = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 7) begin
            failures++; $display("FAIL fetch_diag_addr: got en=%0b addr=%0d expected en=1 addr=7", ram_en, ram_addr);
        end
        tick();
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 8) begin
            failures++; $display("FAIL fetch_up_addr: got en=%0b addr=%0d expected en=1 addr=8", ram_en, ram_addr);
        end
        tick();
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 12) begin
            failures++; $display("FAIL fetch_left_addr: got en=%0b addr=%0d expected en=1 addr=12", ram_en, ram_addr);
        end
        tick();
        checks++;
        if (ram_en !== 1'b0 || ram_addr !== 0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL fetch_drain: got en=%0b addr=%0d ov=%0b busy=%0b expected 0 0 0 1",
                                 ram_en, ram_addr, out_valid, busy);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || diag !== 21 || up !== 24 || left !== 36) begin
            failures++; $display("FAIL fetch_result: got ov=%0b d=%0d u=%0d l=%0d expected 1 21 24 36",
                                 out_valid, diag, up, left);
        end
        $display("test_fetch done");
    endtask

    task automatic test_hold();
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin
                i_idx = 3'd0; j_idx = 3'd0; start = 1'b1;
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || diag !== 21 || up !== 24 || left !== 36 ||
                ram_en !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL hold_stable[%0d]: got ov=%0b d=%0d u=%0d l=%0d en=%0b busy=%0b expected 1 21 24 36 0 1",
                                     k, out_valid, diag, up, left, ram_en, busy);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || diag !== 21) begin
            failures++; $display("FAIL hold_release: got ov=%0b busy=%0b d=%0d expected 0 0 21",
                                 out_valid, busy, diag);
        end
        tick();
        $display("test_hold done");
    endtask

    task automatic test_err();
        int en_seen = 0;
        i_idx = 3'd4; j_idx = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        if (ram_en) en_seen++;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL err_pulse: got err=%0b busy=%0b expected 1 0", err, busy);
        end
        tick();
        if (ram_en) en_seen++;
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || en_seen != 0) begin
            failures++; $display("FAIL err_after: got err=%0b busy=%0b en_seen=%0d expected 0 0 0", err, busy, en_seen);
        end
        $display("test_err done");
    endtask

    task automatic test_reset_mid();
        int ov_seen = 0;
        i_idx = 3'd1; j_idx = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, ram_en, out_valid, err} !== 4'b0000 || ram_addr !== '0 ||
            diag !== '0 || up !== '0 || left !== '0) begin
            failures++; $display("FAIL reset_mid: got busy=%0b en=%0b ov=%0b addr=%0d d=%0d expected all zero",
                                 busy, ram_en, out_valid, ram_addr, diag);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        checks++;
        if (ov_seen != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_no_valid: got ov_seen=%0d busy=%0b expected 0 0", ov_seen, busy);
        end
        i_idx = 3'd0; j_idx = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_addr0", int'(ram_addr), 0);
        tick();
        chk("restart_addr1", int'(ram_addr), 1);
        tick();
        chk("restart_addr2", int'(ram_addr), 5);
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || diag !== 0 || up !== 3 || left !== 15) begin
            failures++; $display("FAIL restart_result: got ov=%0b d=%0d u=%0d l=%0d expected 1 0 3 15",
                                 out_valid, diag, up, left);
        end
        tick();
        chk("restart_pulse_width", int'(out_valid), 0);
        out_ready = 1'b0;
        tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_rdlat3();
        i3 = 3'd3; j3 = 3'd3; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("lat3_addr_diag", int'(ram_addr3), 18);
        tick();
        chk("lat3_addr_up", int'(ram_addr3), 19);
        tick();
        chk("lat3_addr_left", int'(ram_addr3), 23);
        tick(); tick(); tick();
        chk("lat3_valid_early", int'(out_valid3), 0);
        tick();
        checks++;
        if (out_valid3 !== 1'b1 || diag3 !== 54 || up3 !== 57 || left3 !== 69) begin
            failures++; $display("FAIL lat3_result: got ov=%0b d=%0d u=%0d l=%0d expected 1 54 57 69",
                                 out_valid3, diag3, up3, left3);
        end
        out_ready3 = 1'b1;
        tick();
        out_ready3 = 1'b0;
        chk("lat3_release", int'(busy3), 0);
        $display("test_rdlat3 done");
    endtask

    task automatic test_back_to_back();
        int rises[$];
        int en_cnt = 0;
        logic prev_en = 1'b0;
        i_idx = 3'd1; j_idx = 3'd1; out_ready = 1'b1; start = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (ram_en && !prev_en) rises.push_back(c);
            if (ram_en) en_cnt++;
            prev_en = ram_en;
        end
        start = 1'b0;
        chk("b2b_accept_count", rises.size(), 4);
        if (rises.size() >= 3) begin
            chk("b2b_period_1", rises[1] - rises[0], 6);
            chk("b2b_period_2", rises[2] - rises[1], 6);
        end
        chk("b2b_issue_cycles", en_cnt, 12);
        repeat (10) tick();
        out_ready = 1'b0;
        chk("b2b_idle_after", int'(busy), 0);
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_hold();
        test_err();
        test_reset_mid();
        test_rdlat3();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
